// File: rtl/axi_rd_pkg.sv
// Shared constants, FSM states and helpers for the AXI4 burst read master.
package axi_rd_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_4K         = 4096;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ADDR,
    DRAIN,
    DONE
  } rd_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    return result;
  endfunction

endpackage

// File: rtl/axi_rd_skid.sv
// Two-entry skid buffer between the AXI R channel and the output stream.
module axi_rd_skid #(
  parameter int unsigned W = 65
) (
  input  logic         sys_clock,
  input  logic         async_reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, tail_q;
  logic         push, pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = count_q != 2'd0;
  assign out_data  = head_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  // in_ready is registered from the next occupancy, so it still means "not full"
  always_ff @(posedge sys_clock or negedge async_reset) begin
    if (!async_reset) begin
      count_q  <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
      in_ready <= 1'b0;
    end else begin
      count_q  <= count_d;
      in_ready <= count_d != 2'd2;
      if (pop) head_q <= tail_q;
      if (push) begin
        if (count_q == 2'd0 || (count_q == 2'd1 && pop)) head_q <= in_data;
        else                                             tail_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/axi_mread_burst.sv
// AXI4 read master: splits one (address, byte count) command into INCR bursts.
module axi_mread_burst
  import axi_rd_pkg::*;
#(
  parameter int unsigned D_WIDTH         = 64,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic               sys_clock,
  input  logic               async_reset,
  input  logic               i_cmd_valid,
  output logic               or_cmd_ready,
  input  logic [31:0]        i_cmd_addr,
  input  logic [31:0]        i_cmd_bytes,
  output logic               or_busy,
  output logic               or_done,
  output logic               or_err,
  output logic [31:0]        or_ar_addr,
  output logic [7:0]         or_ar_len,
  output logic               or_ar_valid,
  input  logic               i_ar_ready,
  output logic [2:0]         o_ar_size,
  output logic [1:0]         o_ar_burst,
  input  logic [D_WIDTH-1:0] i_r_data,
  input  logic [1:0]         i_r_resp,
  input  logic               i_r_last,
  input  logic               i_r_valid,
  output logic               or_r_ready,
  output logic [D_WIDTH-1:0] o_dout_data,
  output logic               o_dout_valid,
  output logic               o_dout_last,
  input  logic               i_dout_ready
);

  localparam int unsigned BB      = D_WIDTH / 8;
  localparam int unsigned SIZE    = clog2(BB);
  localparam int unsigned PW      = (MAX_OUTSTANDING > 1) ? clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] BB_MASK = 32'(BB - 1);

  rd_state_e   state_q, state_d;
  logic [31:0] addr_q, rem_q, rem_after, last_idx_q, r_cnt_q;
  logic [8:0]  cur_beats_q;
  logic [3:0]  outstanding_q;
  logic [7:0]  beat_q;
  logic        err_q, err_d, reject_q, last_seen_q;
  logic [7:0]  len_mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;

  logic        accept, bad_cmd, ar_hs, r_hs, exp_last, burst_end, final_hs, r_last_out;
  logic [12:0] page_room;
  logic [31:0] page_beats, burst_beats;
  logic [D_WIDTH:0] skid_out;

  assign o_ar_size  = 3'(SIZE);
  assign o_ar_burst = AXI_BURST_INCR;

  assign accept    = i_cmd_valid && or_cmd_ready;
  assign bad_cmd   = ((i_cmd_addr & BB_MASK) != '0) || ((i_cmd_bytes & BB_MASK) != '0) ||
                     (i_cmd_bytes == '0);
  assign ar_hs     = or_ar_valid && i_ar_ready;
  assign r_hs      = i_r_valid && or_r_ready;
  assign exp_last  = beat_q == len_mem[rd_ptr_q];
  // A missing last still closes the burst once the expected count is reached
  assign burst_end = r_hs && (outstanding_q != '0) && (i_r_last || exp_last);
  assign final_hs  = o_dout_valid && i_dout_ready && o_dout_last;
  assign rem_after = rem_q - 32'(cur_beats_q);
  assign r_last_out = r_cnt_q == last_idx_q;

  always_comb begin
    page_room   = 13'(AXI_4K) - {1'b0, addr_q[11:0]};
    page_beats  = 32'(page_room) >> SIZE;
    burst_beats = rem_q;
    if (burst_beats > 32'(MAX_BURST)) burst_beats = 32'(MAX_BURST);
    if (burst_beats > page_beats)     burst_beats = page_beats;
  end

  always_comb begin
    err_d = err_q;
    if (accept) err_d = bad_cmd;
    if (r_hs && ((i_r_resp != AXI_RESP_OKAY) ||
                 ((outstanding_q != '0) && (i_r_last != exp_last))))
      err_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = CALC;
      CALC:  if (reject_q)                                state_d = DONE;
             else if (outstanding_q < 4'(MAX_OUTSTANDING)) state_d = ADDR;
      ADDR:  if (ar_hs) state_d = (rem_after != '0) ? CALC : DRAIN;
      DRAIN: if (outstanding_q == '0 && (last_seen_q || final_hs)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge async_reset) begin
    if (!async_reset) begin
      state_q       <= IDLE;
      or_cmd_ready  <= 1'b1;
      or_busy       <= 1'b0;
      or_done       <= 1'b0;
      or_err        <= 1'b0;
      or_ar_valid   <= 1'b0;
      or_ar_addr    <= '0;
      or_ar_len     <= '0;
      addr_q        <= '0;
      rem_q         <= '0;
      last_idx_q    <= '0;
      r_cnt_q       <= '0;
      cur_beats_q   <= '0;
      outstanding_q <= '0;
      beat_q        <= '0;
      err_q         <= 1'b0;
      reject_q      <= 1'b0;
      last_seen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      or_cmd_ready <= state_d == IDLE;
      or_busy      <= state_d != IDLE;
      or_done      <= state_d == DONE;
      or_err       <= (state_d == DONE) && err_d;
      or_ar_valid  <= state_d == ADDR;
      err_q        <= err_d;

      if (accept) begin
        addr_q      <= i_cmd_addr;
        rem_q       <= i_cmd_bytes >> SIZE;
        last_idx_q  <= (i_cmd_bytes >> SIZE) - 32'd1;
        reject_q    <= bad_cmd;
        r_cnt_q     <= '0;
        beat_q      <= '0;
        last_seen_q <= 1'b0;
      end else begin
        if (r_hs)     r_cnt_q     <= r_cnt_q + 32'd1;
        if (r_hs)     beat_q      <= burst_end ? 8'd0 : beat_q + 8'd1;
        if (final_hs) last_seen_q <= 1'b1;
      end

      if (state_q == CALC && state_d == ADDR) begin
        or_ar_addr  <= addr_q;
        or_ar_len   <= 8'(burst_beats - 32'd1);
        cur_beats_q <= 9'(burst_beats);
      end

      if (ar_hs) begin
        addr_q <= addr_q + (32'(cur_beats_q) << SIZE);
        rem_q  <= rem_after;
      end

      if (ar_hs && !burst_end)      outstanding_q <= outstanding_q + 4'd1;
      else if (burst_end && !ar_hs) outstanding_q <= outstanding_q - 4'd1;
    end
  end

  // Per-burst len FIFO, pushed on AR handshake and popped at each burst end
  always_ff @(posedge sys_clock or negedge async_reset) begin
    if (!async_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) len_mem[i] <= '0;
    end else begin
      if (ar_hs) begin
        len_mem[wr_ptr_q] <= or_ar_len;
        wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (burst_end)
        rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  axi_rd_skid #(
    .W (D_WIDTH + 1)
  ) u_skid (
    .sys_clock   (sys_clock),
    .async_reset (async_reset),
    .in_data     ({r_last_out, i_r_data}),
    .in_valid    (i_r_valid),
    .in_ready    (or_r_ready),
    .out_data    (skid_out),
    .out_valid   (o_dout_valid),
    .out_ready   (i_dout_ready)
  );

  assign o_dout_last = skid_out[D_WIDTH];
  assign o_dout_data = skid_out[D_WIDTH-1:0];

endmodule

// File: doc/axi_mread_burst.md
# axi_mread_burst

Parametrised AXI4 read master that turns one command (start address, byte count) into a sequence of INCR bursts. Bursts are capped at `MAX_BURST` beats, never cross a 4 KB boundary, and up to `MAX_OUTSTANDING` may be in flight. Read data leaves through a registered valid/ready stream with a whole-transfer last flag. The block sits between DMA/control logic and the PS/PL AXI HP/ACP slave ports.

## Interface
- `D_WIDTH`, 64: data width in bits; power of two, 32..1024. Beat bytes `BB = D_WIDTH/8`.
- `MAX_BURST`, 16: maximum beats per burst; power of two, 1..256.
- `MAX_OUTSTANDING`, 4: maximum AR handshakes not yet closed by an R-last; 1..8.

Ports:
- `sys_clock` in 1: clock.
- `async_reset` in 1: reset, asynchronous, active-low.
- `i_cmd_valid` in 1, `or_cmd_ready` out 1: command handshake.
- `i_cmd_addr` in 32: start byte address.
- `i_cmd_bytes` in 32: transfer length in bytes.
- `or_busy` out 1: command in progress.
- `or_done` out 1: one-cycle pulse at command end.
- `or_err` out 1: valid with `or_done`; 1 means the command failed.
- `or_ar_addr` out 32, `or_ar_len` out 8, `or_ar_valid` out 1, `i_ar_ready` in 1: AXI read address channel.
- `o_ar_size` out 3: constant clog2(BB).
- `o_ar_burst` out 2: constant INCR (2'b01).
- `i_r_data` in D_WIDTH, `i_r_resp` in 2, `i_r_last` in 1, `i_r_valid` in 1, `or_r_ready` out 1: AXI read data channel.
- `o_dout_data` out D_WIDTH, `o_dout_valid` out 1, `o_dout_last` out 1, `i_dout_ready` in 1: output stream.

## Operation
- **Reset values:** every `or_*` output is 0, except `or_cmd_ready`, which is 1. `o_dout_valid` and `o_dout_last` are 0. Reset is asynchronous and can land mid-command. It drops all state with no drain, so the system must reset the slave at the same time.
- **Command accept:** a command is accepted on `i_cmd_valid && or_cmd_ready`. `or_cmd_ready` is 1 only in IDLE.
- **Command reject:** a command is rejected if `i_cmd_addr % BB != 0`, `i_cmd_bytes % BB != 0`, or `i_cmd_bytes == 0`. The FSM goes to DONE with the error flag set and issues no AXI traffic.
- **Address FSM:**
  - IDLE → CALC on accept.
  - CALC computes `len = min(rem_beats, MAX_BURST, (4096 - addr[11:0]) / BB)`.
  - CALC → ADDR when `outstanding < MAX_OUTSTANDING`; otherwise it stays in CALC.
  - ADDR holds `or_ar_valid` with address and len stable until `i_ar_ready`.
  - On the AR handshake: `addr += len*BB`, `rem_beats -= len`, `outstanding++`. Then go to CALC if `rem_beats != 0`, else to DRAIN.
  - DRAIN → DONE when `outstanding == 0` and the final beat has left `o_dout`.
  - DONE lasts one cycle: `or_done` = 1, then back to IDLE.
- **Outstanding counter:** increments on an AR handshake and decrements on an R handshake with `i_r_last`. When both happen in the same cycle the counter is unchanged.
- **R side:**
  - Beats are counted against the per-burst len, held in a MAX_OUTSTANDING-deep len FIFO.
  - `i_r_last` on the wrong beat sets the sticky error. A missing last also sets it, and the counter is still treated as burst end.
  - Any `i_r_resp != OKAY` sets the sticky error.
  - Data is always forwarded; the beat count is never truncated on error.
- **End of command:**
  - `o_dout_last` is 1 on beat `i_cmd_bytes/BB` of the command.
  - `or_err` equals the sticky error at DONE, and the sticky error clears on the next accept.
  - `or_busy` = !IDLE.

## Timing
- `or_ar_valid` rises 2 cycles after the command accept (accept → CALC → ADDR).
- The next AR comes no earlier than 2 cycles after the previous AR handshake.
- `or_r_ready` is registered and equals "skid not full". `o_dout_valid` follows an R handshake by 1 cycle.
- Full output throughput: one beat per cycle while `i_dout_ready` stays high.
- `or_done` pulses 1 cycle after the final `o_dout` handshake.
- For a rejected command, `or_done` and `or_err` pulse 2 cycles after accept.
- `o_dout_*` stay stable while `o_dout_valid && !i_dout_ready`.

## Structure
- **Package `axi_rd_pkg`:**
  - constants `AXI_BURST_INCR`, `AXI_RESP_OKAY`, `AXI_4K = 4096`
  - FSM state enum {IDLE, CALC, ADDR, DRAIN, DONE}
  - clog2 function
- **Sub-module `axi_rd_skid`:** 2-entry skid buffer, parameter W = D_WIDTH+1, carrying data and last. It drives `or_r_ready` and `o_dout_*`.

## Test plan
All scenarios use D_WIDTH=64 (BB=8), MAX_BURST=16, MAX_OUTSTANDING=4.
1. addr 0x1000, bytes 128 → one AR (0x1000, len 15). 16 dout beats, last on the 16th. done with err=0.
2. addr 0x0FF0, bytes 64 → AR (0x0FF0, len 1), then AR (0x1000, len 5). 8 beats. done with err=0.
3. addr 0x2000, bytes 1024, slave withholds R → exactly 4 ARs (0x2000/0x2080/0x2100/0x2180), then `or_ar_valid` stays 0 until the first R-last. Total 8 ARs, 128 beats.
4. 32-beat command, SLVERR on beat 3 → all 32 beats delivered, then done with err=1. A following clean command ends with err=0.
5. addr 0x1004 or bytes 0 → no AR; done and err pulse 2 cycles after accept.
6. Random `i_dout_ready` stalls, then `async_reset` low mid-burst → no data lost or duplicated before the reset. After the reset, all outputs are at reset values and `or_cmd_ready` = 1.
